// File: rtl/serializer_pkg.sv
// Shared types and constants for the serializer front-end scheduler.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE
  } sched_state_t;

  // Length codes the serializer cannot handle; such requests are dropped.
  localparam int unsigned MOD_INV_LO = 1;
  localparam int unsigned MOD_INV_HI = 2;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_DATA_BUS_WIDTH = 16;
  localparam int unsigned DEF_DATA_MOD_WIDTH = 4;
  localparam int unsigned DEF_START_TIMEOUT  = 4;

  function automatic logic mod_is_invalid(input int unsigned mod);
    return (mod >= MOD_INV_LO) && (mod <= MOD_INV_HI);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr_i and wraps.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;

  // Walk from lowest priority (ptr itself) to highest (ptr+1); the last hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/serializer_sched.sv
// Round-robin scheduler feeding serializer_impl one word at a time and holding
// the launched word stable until the serializer reports completion.
module serializer_sched
  import serializer_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
  parameter int unsigned DATA_MOD_WIDTH = DEF_DATA_MOD_WIDTH,
  parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
  localparam int unsigned IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              arst_ni,
  input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*DATA_MOD_WIDTH-1:0] req_mod_i,
  input  logic [NUM_REQ-1:0]                req_val_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [DATA_BUS_WIDTH-1:0]         ser_data_o,
  output logic [DATA_MOD_WIDTH-1:0]         ser_mod_o,
  output logic                              ser_val_o,
  input  logic                              ser_busy_i,
  output logic [IDX_W-1:0]                  grant_id_o,
  output logic                              active_o,
  output logic                              drop_o,
  output logic                              timeout_o
);

  localparam int unsigned CNT_W = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;

  sched_state_t              state_q;
  logic [IDX_W-1:0]          last_grant_q;
  logic [IDX_W-1:0]          id_q;
  logic [DATA_BUS_WIDTH-1:0] data_q;
  logic [DATA_MOD_WIDTH-1:0] mod_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      active_q;
  logic                      ser_val_q;
  logic                      drop_q;
  logic                      timeout_q;

  logic [NUM_REQ-1:0]        gnt;
  logic [IDX_W-1:0]          gnt_idx;
  logic [DATA_BUS_WIDTH-1:0] sel_data;
  logic [DATA_MOD_WIDTH-1:0] sel_mod;
  logic                      accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_val_i),
    .ptr_i (last_grant_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_mod  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_data = req_data_i[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
        sel_mod  = req_mod_i[i*DATA_MOD_WIDTH +: DATA_MOD_WIDTH];
      end
    end
  end

  assign accept      = (state_q == IDLE) && (|gnt);
  assign req_ready_o = (state_q == IDLE) ? gnt : '0;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      // NOTE: the holding registers are reset as well so nothing undefined can reach the serializer.
      id_q         <= '0;
      data_q       <= '0;
      mod_q        <= '0;
      cnt_q        <= '0;
      active_q     <= 1'b0;
      ser_val_q    <= 1'b0;
      drop_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge values.
      ser_val_q <= 1'b0;
      drop_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q       <= sel_data;
            mod_q        <= sel_mod;
            id_q         <= gnt_idx;
            last_grant_q <= gnt_idx;
            if (mod_is_invalid(32'(sel_mod))) begin
              drop_q <= 1'b1;
            end else begin
              state_q   <= LAUNCH;
              ser_val_q <= 1'b1;
              active_q  <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state_q <= WAIT_START;
          cnt_q   <= '0;
        end
        WAIT_START: begin
          if (ser_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNT_W'(START_TIMEOUT - 2)) begin
            // This cycle's increment would reach START_TIMEOUT-1: abort.
            state_q   <= IDLE;
            active_q  <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!ser_busy_i) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign ser_data_o = active_q ? data_q : '0;
  assign ser_mod_o  = active_q ? mod_q  : '0;
  assign grant_id_o = active_q ? id_q   : '0;
  assign active_o   = active_q;
  assign ser_val_o  = ser_val_q;
  assign drop_o     = drop_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_serializer_sched.sv
// Directed and randomized checks of serializer_sched against a transaction-level model.
module tb_serializer_sched;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int MW   = 4;
  localparam int TO   = 4;

  logic              clk_i = 1'b0;
  logic              arst_ni;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*MW-1:0] req_mod;
  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_ready_o;
  logic [DW-1:0]     ser_data_o;
  logic [MW-1:0]     ser_mod_o;
  logic              ser_val_o;
  logic              ser_busy;
  logic [1:0]        grant_id_o;
  logic              active_o;
  logic              drop_o;
  logic              timeout_o;

  int total = 0;
  int bad   = 0;
  int last_m;

  always #5 clk_i = ~clk_i;

  serializer_sched #(
    .NUM_REQ(NREQ), .DATA_BUS_WIDTH(DW), .DATA_MOD_WIDTH(MW), .START_TIMEOUT(TO)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_data_i  (req_data),
    .req_mod_i   (req_mod),
    .req_val_i   (req_val),
    .req_ready_o (req_ready_o),
    .ser_data_o  (ser_data_o),
    .ser_mod_o   (ser_mod_o),
    .ser_val_o   (ser_val_o),
    .ser_busy_i  (ser_busy),
    .grant_id_o  (grant_id_o),
    .active_o    (active_o),
    .drop_o      (drop_o),
    .timeout_o   (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready_o), 0);
    check({tag, "_val"}, 32'(ser_val_o), 0);
    check({tag, "_data"}, 32'(ser_data_o), 0);
    check({tag, "_mod"}, 32'(ser_mod_o), 0);
    check({tag, "_id"}, 32'(grant_id_o), 0);
    check({tag, "_active"}, 32'(active_o), 0);
    check({tag, "_drop"}, 32'(drop_o), 0);
    check({tag, "_timeout"}, 32'(timeout_o), 0);
  endtask

  // Model: winner is the first valid requester met when walking the rotation
  // that begins just after the previous winner.
  function automatic int pick(input logic [NREQ-1:0] val, input int last);
    int order[$];
    for (int k = 1; k <= NREQ; k++) order.push_back((last + k) % NREQ);
    foreach (order[i]) if (val[order[i]]) return order[i];
    return -1;
  endfunction

  function automatic bit mod_bad(input logic [MW-1:0] m);
    return (m == 4'd1) || (m == 4'd2);
  endfunction

  // Present the current inputs, check the model's winner and update the model pointer.
  task automatic offer(input string tag, output int w);
    #1;
    w = pick(req_val, last_m);
    check(tag, 32'(req_ready_o), (w < 0) ? 0 : (32'd1 << w));
    if (w >= 0) last_m = w;
  endtask

  // Accept edge through completion. Busy rises d cycles after LAUNCH and stays
  // high for len cycles; d >= TO means it never comes and the launch aborts.
  // Returns in the first IDLE cycle.
  task automatic run_txn(input int id, input int d, input int len,
                         input bit clear, input bit ghost);
    bit to;
    int c_end;
    logic [DW-1:0] data;
    logic [MW-1:0] modv;
    data  = req_data[id*DW +: DW];
    modv  = req_mod[id*MW +: MW];
    to    = (d >= TO);
    c_end = to ? TO : d + len + 1;
    tick();
    if (clear) req_val[id] = 1'b0;
    ser_busy = ghost;
    #1;
    check("launch_val", 32'(ser_val_o), 1);
    check("launch_data", 32'(ser_data_o), 32'(data));
    check("launch_mod", 32'(ser_mod_o), 32'(modv));
    check("launch_id", 32'(grant_id_o), id);
    check("launch_ready", 32'(req_ready_o), 0);
    check("launch_drop", 32'(drop_o), 0);
    for (int c = 1; c <= c_end; c++) begin
      tick();
      ser_busy = !to && (c >= d) && (c < d + len);
      #1;
      if (c < c_end) begin
        check("hold_active", 32'(active_o), 1);
        check("hold_val", 32'(ser_val_o), 0);
        check("hold_data", 32'(ser_data_o), 32'(data));
        check("hold_id", 32'(grant_id_o), id);
        check("hold_ready", 32'(req_ready_o), 0);
        check("hold_timeout", 32'(timeout_o), 0);
      end
    end
    check("done_active", 32'(active_o), 0);
    check("done_data", 32'(ser_data_o), 0);
    check("done_id", 32'(grant_id_o), 0);
    check("done_timeout", 32'(timeout_o), 32'(to));
  endtask

  task automatic run_drop(input int id, input bit clear);
    tick();
    if (clear) req_val[id] = 1'b0;
    #1;
    check("drop_pulse", 32'(drop_o), 1);
    check("drop_val", 32'(ser_val_o), 0);
    check("drop_active", 32'(active_o), 0);
    check("drop_data", 32'(ser_data_o), 0);
  endtask

  task automatic set_req(input int id, input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_data[id*DW +: DW] = d;
    req_mod[id*MW +: MW]  = m;
  endtask

  initial begin
    int w;
    arst_ni  = 1'b0;
    req_data = '0;
    req_mod  = '0;
    req_val  = '0;
    ser_busy = 1'b0;
    last_m   = NREQ - 1;

    // Reset state
    tick();
    tick();
    check_all_zero("rst");
    arst_ni = 1'b1;
    tick();
    check_all_zero("post_rst");

    // Busy while idle is ignored
    ser_busy = 1'b1;
    tick();
    tick();
    #1;
    check("idle_busy_active", 32'(active_o), 0);
    check("idle_busy_val", 32'(ser_val_o), 0);
    ser_busy = 1'b0;

    // Single request from requester 2
    set_req(2, 16'hA5C3, 4'd0);
    req_val = 4'b0100;
    offer("single_ready", w);
    run_txn(w, 1, 5, 1, 0);

    // Reset during WAIT_DONE with busy high
    set_req(1, 16'h1234, 4'd8);
    req_val = 4'b0010;
    offer("rstmid_ready", w);
    tick();
    req_val = '0;
    ser_busy = 1'b1;
    tick();
    tick();
    #1;
    check("rstmid_pre_active", 32'(active_o), 1);
    arst_ni = 1'b0;
    #1;
    check_all_zero("rstmid");
    tick();
    ser_busy = 1'b0;
    arst_ni  = 1'b1;
    last_m   = NREQ - 1;

    // Continuous requests from all: grant order 0,1,2,3,0
    req_val = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < NREQ; r++) set_req(r, 16'($urandom), 4'($urandom_range(3, 15)));
      offer("rot_ready", w);
      check("rot_order", w, k % NREQ);
      run_txn(w, $urandom_range(1, 3), $urandom_range(1, 3), 0, 0);
    end

    // Requester 1 with an unsupported length is dropped and loses its turn
    set_req(1, 16'hBEEF, 4'd2);
    offer("drop_ready", w);
    check("drop_winner", w, 1);
    run_drop(w, 0);
    for (int k = 0; k < 3; k++) begin
      offer("after_drop_ready", w);
      check("after_drop_order", w, (k + 2) % NREQ);
      run_txn(w, 1, 2, 0, 0);
    end
    offer("drop_again_ready", w);
    check("drop_again_winner", w, 1);
    run_drop(w, 1);
    req_val = '0;

    // Start timeout with no busy, then with busy only during LAUNCH
    set_req(2, 16'h0F0F, 4'd0);
    req_val = 4'b0100;
    offer("to_ready", w);
    run_txn(w, TO, 1, 1, 0);
    set_req(3, 16'hF0F0, 4'd5);
    req_val = 4'b1000;
    offer("to_ready_after", w);
    run_txn(w, TO, 1, 1, 1);

    // Back-to-back: requester 3 pending while 0 is served
    set_req(0, 16'h5555, 4'd0);
    set_req(3, 16'hAAAA, 4'd9);
    req_val = 4'b1001;
    offer("b2b_first", w);
    check("b2b_first_winner", w, 0);
    run_txn(w, 1, 3, 1, 0);
    offer("b2b_second", w);
    check("b2b_second_winner", w, 3);
    run_txn(w, 2, 1, 1, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < NREQ; r++) set_req(r, 16'($urandom), 4'($urandom));
      req_val = 4'($urandom_range(1, 15));
      offer("rand_ready", w);
      if (mod_bad(req_mod[w*MW +: MW])) run_drop(w, 1);
      else run_txn(w, $urandom_range(1, 5), $urandom_range(1, 4), 1, 0);
      req_val = '0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
